tt_um_delosreyesjordan_hdl: RTL and testbench

Reaction-time tester top-level, module `tt_um_DelosReyesJordan_HDL`, the TinyTapeout user tile. A start press arms a pseudo-random delay, after which a GO LED lights. The block then counts milliseconds until the react button is pressed and presents the result in binary on the output pins. A press before GO is flagged as a false start.

---
 rtl/tt_um_delosreyesjordan_hdl_pkg.sv | 7 +
 rtl/tt_um_delosreyesjordan_hdl_btn_sync_edge.sv | 18 +
 rtl/tt_um_delosreyesjordan_hdl.sv | 83 ++++++++
 tb/tb_tt_um_delosreyesjordan_hdl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/tt_um_delosreyesjordan_hdl_pkg.sv
// tt_um_delosreyesjordan_hdl_pkg: shared states and constants for the reaction-time tester.
package tt_um_delosreyesjordan_hdl_pkg;
    typedef enum logic [2:0] {IDLE, WAIT, GO, DONE, EARLY} state_t;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [13:0] MS_MAX = 14'd9999;
endpackage

// File: rtl/tt_um_delosreyesjordan_hdl_btn_sync_edge.sv
// btn_sync_edge: two-flop synchronizer followed by a registered rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    logic [2:0] sh;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh    <= '0;
            pulse <= 1'b0;
        end else begin
            sh    <= {sh[1:0], btn};
            pulse <= sh[1] & ~sh[2];
        end
    end
endmodule

// File: rtl/tt_um_delosreyesjordan_hdl.sv
// tt_um_delosreyesjordan_hdl: reaction-time tester with random GO delay, ms result and best-time tracking.
module tt_um_delosreyesjordan_hdl
    import tt_um_delosreyesjordan_hdl_pkg::*;
#(
    parameter int TICK_DIV     = 10000,
    parameter int MIN_DELAY_MS = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int PW = $clog2(TICK_DIV + 1);
    state_t state;
    logic start_e, react_e, tick, best_valid;
    logic [15:0] lfsr;
    logic [PW-1:0] presc;
    logic [13:0] ms_cnt, ms_next, delay, result, best, disp;
    logic unused;
    assign unused = &{1'b0, ena, uio_in, ui_in[7:3]};
    btn_sync_edge u_start (.clk(clk), .rst_n(rst_n), .btn(ui_in[0]), .pulse(start_e));
    btn_sync_edge u_react (.clk(clk), .rst_n(rst_n), .btn(ui_in[1]), .pulse(react_e));
    assign tick    = presc == PW'(TICK_DIV - 1);
    assign ms_next = (ms_cnt == MS_MAX) ? ms_cnt : ms_cnt + 14'd1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= LFSR_SEED;
        else
            lfsr <= lfsr[0] ? ({1'b0, lfsr[15:1]} ^ LFSR_TAPS) : {1'b0, lfsr[15:1]};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            ms_cnt     <= '0;
            delay      <= '0;
            result     <= '0;
            best       <= MS_MAX;
            best_valid <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            // start has priority over react and restarts any phase with a fresh delay
            if (start_e) begin
                state  <= WAIT;
                delay  <= 14'(MIN_DELAY_MS) + {4'd0, lfsr[9:0]};
                ms_cnt <= '0;
                presc  <= '0;
            end else if (state == WAIT) begin
                if (react_e) begin
                    state <= EARLY;
                    presc <= '0;
                end else if (tick) begin
                    state  <= (ms_next == delay) ? GO : WAIT;
                    ms_cnt <= (ms_next == delay) ? '0 : ms_next;
                end
            end else if (state == GO) begin
                if (react_e) begin
                    state  <= DONE;
                    result <= ms_cnt;
                    presc  <= '0;
                    if (!best_valid || ms_cnt < best) begin
                        best       <= ms_cnt;
                        best_valid <= 1'b1;
                    end
                end else if (tick) begin
                    ms_cnt <= ms_next;
                    if (ms_next == MS_MAX) begin
                        state  <= DONE;
                        result <= MS_MAX;
                    end
                end
            end
        end
    end
    assign disp    = ui_in[2] ? best : result;
    assign uo_out  = disp[7:0];
    assign uio_out = {state == EARLY, state == GO, disp[13:8]};
    assign uio_oe  = 8'hFF;
endmodule

// File: tb/tb_tt_um_delosreyesjordan_hdl.sv
// tb_tt_um_delosreyesjordan_hdl: directed checks of reset, runs, false start, best, timeout and async reset.
module tb_tt_um_delosreyesjordan_hdl;
    logic clk = 1'b0;
    logic rst_n, ena;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
    logic [13:0] disp;
    int checks = 0;
    int passed = 0;
    logic ok, seen;

    tt_um_delosreyesjordan_hdl #(.TICK_DIV(4), .MIN_DELAY_MS(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;
    assign disp = {uio_out[5:0], uo_out};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic press(input int b);
        ui_in[b] = 1'b1;
        repeat (4) @(negedge clk);
        ui_in[b] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_go(output logic got);
        got = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (uio_out[6]) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic run(input int n);
        press(0);
        wait_go(ok);
        check("run_go_seen", 16'(ok), 16'd1);
        repeat (4 * n) @(negedge clk);
        ui_in[1] = 1'b1;
        repeat (4) @(negedge clk);
        ui_in[1] = 1'b0;
        check("run_go_off", 16'(uio_out[6]), 16'd0);
        check("run_result", 16'(disp), 16'(n));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        ui_in = '0; uio_in = '0; ena = 1'b1; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_uo_out", 16'(uo_out), 16'd0);
        check("rst_uio_out", 16'(uio_out), 16'd0);
        check("rst_uio_oe", 16'(uio_oe), 16'hFF);
        ui_in[2] = 1'b1; #1;
        check("rst_best_invalid", 16'(disp), 16'd9999);
        ui_in[2] = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        run(10);
        ui_in[2] = 1'b1; #1;
        check("best_after_10", 16'(disp), 16'd10);
        ui_in[2] = 1'b0;

        press(0);
        press(1);
        check("false_start_flag", 16'(uio_out[7]), 16'd1);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (uio_out[6]) seen = 1'b1;
        end
        check("false_start_no_go", 16'(seen), 16'd0);
        check("false_start_result_kept", 16'(disp), 16'd10);
        press(0);
        check("false_start_cleared", 16'(uio_out[7:6]), 16'd0);

        run(5);
        run(8);
        ui_in[2] = 1'b1; #1;
        check("best_is_5", 16'(disp), 16'd5);
        ui_in[2] = 1'b0; #1;
        check("result_is_8", 16'(disp), 16'd8);

        press(1);
        check("done_react_ignored", 16'(disp), 16'd8);
        check("done_flags", 16'(uio_out[7:6]), 16'd0);

        press(0);
        wait_go(ok);
        check("restart_go_seen", 16'(ok), 16'd1);
        press(0);
        check("restart_go_off", 16'(uio_out[6]), 16'd0);
        check("restart_result_kept", 16'(disp), 16'd8);

        wait_go(ok);
        check("timeout_go_seen", 16'(ok), 16'd1);
        ok = 1'b0;
        for (int i = 0; i < 41000; i++) begin
            @(negedge clk);
            if (!uio_out[6]) begin
                ok = 1'b1;
                break;
            end
        end
        check("timeout_reached", 16'(ok), 16'd1);
        check("timeout_result", 16'(disp), 16'd9999);
        check("timeout_flags", 16'(uio_out[7:6]), 16'd0);
        ui_in[2] = 1'b1; #1;
        check("timeout_best_kept", 16'(disp), 16'd5);
        ui_in[2] = 1'b0;

        @(negedge clk);
        press(0);
        wait_go(ok);
        check("areset_go_seen", 16'(ok), 16'd1);
        repeat (20) @(negedge clk);
        check("areset_in_go", 16'(uio_out[6]), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check("areset_uo_out", 16'(uo_out), 16'd0);
        check("areset_uio_out", 16'(uio_out), 16'd0);
        ui_in[2] = 1'b1; #1;
        check("areset_best_cleared", 16'(disp), 16'd9999);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
